tt_um_leg_solver: RTL and testbench
===================================

Name: tt_um_leg_solver

Overview:
- Inverse companion of the hypotenuse (sqrt(x^2+y^2)) tile: given hypotenuse r on ui_in and one leg x on uio_in, computes the other leg y = isqrt(r^2 - x^2).
- Iterative, multiplier-free datapath: 8-cycle shift-add squaring followed by an 8-cycle restoring square root.
- Computation restarts automatically whenever the operands change. The last result is held on uo_out.
- Sits as a standalone TinyTapeout user tile with the standard tile pinout.

Parameters:
- ROUND, 0, 0 = floor result; 1 = round to nearest (ties round up), saturating at 255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  tile enable; when low, the FSM and all registers hold
- ui_in  input  8  r, hypotenuse (unsigned)
- uio_in  input  8  x, known leg (unsigned)
- uo_out  output  8  y, result register
- uio_out  output  8  tied 8'h00
- uio_oe  output  8  tied 8'h00; all uio pins are inputs

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE
  - r_q=0, x_q=0
  - sq_r=sq_x=0, d=0, root=0, rem=0, cnt=0
  - uo_out=8'h00
- All state updates occur on posedge clk, and only when ena=1.
- IDLE:
  - If {ui_in,uio_in} != {r_q,x_q}: latch r_q<=ui_in, x_q<=uio_in, clear accumulators, cnt<=0, go to SQUARE.
  - Otherwise stay in IDLE.
  - Reset operands (0,0) give result 0, so no start is needed after reset.
- SQUARE, 8 cycles, cnt 0..7:
  - Bit cnt of r_q, if set, adds r_q<<cnt into 16-bit sq_r.
  - x_q is squared into sq_x the same way.
  - On cnt=7: d <= (x_q >= r_q) ? 0 : sq_r_final - sq_x_final. The final value includes the cnt=7 term.
  - Then cnt<=0 and go to ROOT.
- ROOT, 8 cycles:
  - Restoring digit-by-digit square root of 16-bit d, 2 bits consumed per cycle, MSB pair first.
  - 8-bit root, 10-bit remainder rem.
  - On the 8th cycle go to DONE.
- DONE, 1 cycle:
  - ROUND=0: uo_out <= root.
  - ROUND=1: uo_out <= (rem > root && root != 255) ? root+1 : root.
  - Here rem = d - root^2, and the test rem > root is equivalent to d >= (root+0.5)^2 for integers.
  - Then return to IDLE.
- Latency: the capture edge is edge 0. uo_out updates on edge 17. The earliest next capture is edge 18.
- Operand changes during SQUARE/ROOT/DONE are ignored. On return to IDLE they are compared against r_q/x_q, and a new run starts if they differ.
  - Therefore the final uo_out always corresponds to the final stable inputs.
- uo_out is stable (unchanged) except on the DONE edge; no glitching through intermediate values.
- x >= r (including x = r) yields result 0.
- Width rules:
  - Squares are 16-bit; 255^2 = 65025 fits.
  - d <= 65025, so root <= 255.
  - All arithmetic is unsigned.
- ena=0 mid-run: the FSM freezes (cnt, state and datapath hold) and resumes when ena returns to 1; the result is unaffected.
- Reset mid-run: all registers clear immediately (async). After rst_n is released, current inputs that are non-zero start a fresh run.

Test Plan:
- Reset then r=5, x=3; wait 18 cycles -> uo_out=4. uo_out stays 0 until edge 17, then holds 4.
- r=25, x=7 -> 24. Then r=255, x=0 -> 255. Then r=20, x=10 -> 17 with ROUND=0 and ROUND=1.
- r=18, x=10 (d=224) -> ROUND=0 gives 14, ROUND=1 gives 15. Also r=3, x=5 -> 0, and r=9, x=9 -> 0.
- Start r=25, x=7, change to r=5, x=4 at cycle 5 of the run -> uo_out=24 at edge 17, then 3 after a further 18 cycles, with no other intermediate value.
- ena dropped low for 10 cycles mid-ROOT with r=13, x=5 -> uo_out=12, delayed by exactly 10 cycles. Separately, rst_n pulsed mid-SQUARE -> uo_out=0 immediately, then 12 after 18 cycles.
- Hold inputs constant at r=13, x=5 after completion for 50 cycles -> no new run (state stays IDLE) and uo_out stable at 12. uio_oe=0 and uio_out=0 throughout.

Source files
------------

// File: rtl/tt_um_leg_solver.sv
// tt_um_leg_solver: other leg y = isqrt(r^2 - x^2) via shift-add squaring then restoring square root.
// A new run starts whenever the operands differ from the last captured pair.
module tt_um_leg_solver #(
    parameter bit ROUND = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] r_q, r_d, x_q, x_d, root_q, root_d, y_q, y_d;
    logic [15:0] sq_r_q, sq_r_d, sq_x_q, sq_x_d, d_q, d_d, sq_r_nx, sq_x_nx;
    logic [9:0] rem_q, rem_d;
    logic [2:0] cnt_q, cnt_d;
    logic [11:0] trial;
    logic ge;
    assign uio_out = 8'h00;
    assign uio_oe = 8'h00;
    assign uo_out = y_q;
    assign sq_r_nx = sq_r_q + (r_q[cnt_q] ? ({8'd0, r_q} << cnt_q) : 16'd0);
    assign sq_x_nx = sq_x_q + (x_q[cnt_q] ? ({8'd0, x_q} << cnt_q) : 16'd0);
    // Next radicand pair, MSB pair first, appended to the running remainder
    assign trial = {rem_q, d_q[{~cnt_q, 1'b0} +: 2]};
    assign ge = trial >= {2'b00, root_q, 2'b01};
    always_comb begin
        state_d = state_q;
        r_d = r_q;
        x_d = x_q;
        sq_r_d = sq_r_q;
        sq_x_d = sq_x_q;
        d_d = d_q;
        root_d = root_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        y_d = y_q;
        case (state_q)
            IDLE: if ({ui_in, uio_in} != {r_q, x_q}) begin
                r_d = ui_in;
                x_d = uio_in;
                sq_r_d = '0;
                sq_x_d = '0;
                d_d = '0;
                root_d = '0;
                rem_d = '0;
                cnt_d = '0;
                state_d = SQUARE;
            end
            SQUARE: begin
                sq_r_d = sq_r_nx;
                sq_x_d = sq_x_nx;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    d_d = (x_q >= r_q) ? 16'd0 : sq_r_nx - sq_x_nx;
                    state_d = ROOT;
                end
            end
            ROOT: begin
                rem_d = ge ? trial[9:0] - {root_q, 2'b01} : trial[9:0];
                root_d = {root_q[6:0], ge};
                cnt_d = cnt_q + 3'd1;
                state_d = (cnt_q == 3'd7) ? DONE : ROOT;
            end
            default: begin
                y_d = (ROUND && rem_q > {2'b00, root_q} && root_q != 8'hFF) ? root_q + 8'd1 : root_q;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q <= '0;
            x_q <= '0;
            sq_r_q <= '0;
            sq_x_q <= '0;
            d_q <= '0;
            root_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            y_q <= '0;
        end else if (ena) begin
            state_q <= state_d;
            r_q <= r_d;
            x_q <= x_d;
            sq_r_q <= sq_r_d;
            sq_x_q <= sq_x_d;
            d_q <= d_d;
            root_q <= root_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            y_q <= y_d;
        end
    end
endmodule

// File: tb/tb_tt_um_leg_solver.sv
// tb_tt_um_leg_solver: floor and rounding variants checked every cycle against an arithmetic model.
module tb_tt_um_leg_solver;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] ui_in = '0, uio_in = '0;
    logic [7:0] uo0, uo1, uio_out0, uio_out1, uio_oe0, uio_oe1;
    int errors = 0, checks = 0;
    logic [7:0] m_r = '0, m_x = '0, m_y0 = '0, m_y1 = '0;
    int m_left = 0;
    always #5 clk = ~clk;
    tt_um_leg_solver #(.ROUND(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo0), .uio_out(uio_out0), .uio_oe(uio_oe0));
    tt_um_leg_solver #(.ROUND(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1));

    function automatic int leg_d(input int r, input int x);
        return (x >= r) ? 0 : r * r - x * x;
    endfunction
    function automatic logic [7:0] leg_floor(input int r, input int x);
        int d = leg_d(r, x);
        int y = 0;
        while ((y + 1) * (y + 1) <= d) y++;
        return 8'(y);
    endfunction
    function automatic logic [7:0] leg_round(input int r, input int x);
        int d = leg_d(r, x);
        int y = int'(leg_floor(r, x));
        // d >= (y+0.5)^2 for integer d is d >= y^2 + y + 1
        if (y != 255 && d >= y * y + y + 1) y++;
        return 8'(y);
    endfunction

    // A run is 17 edges after the capture edge; operands are rechecked only once idle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r <= '0;
            m_x <= '0;
            m_y0 <= '0;
            m_y1 <= '0;
            m_left <= 0;
        end else if (ena) begin
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_y0 <= leg_floor(int'(m_r), int'(m_x));
                    m_y1 <= leg_round(int'(m_r), int'(m_x));
                end
            end else if ({ui_in, uio_in} != {m_r, m_x}) begin
                m_r <= ui_in;
                m_x <= uio_in;
                m_left <= 17;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        chk("model_y_floor", int'(uo0), int'(m_y0));
        chk("model_y_round", int'(uo1), int'(m_y1));
        chk("uio_tied", int'({uio_out0, uio_oe0, uio_out1, uio_oe1}), 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_in(input int r, input int x);
        ui_in = 8'(r);
        uio_in = 8'(x);
    endtask
    task automatic lit(input string name, input int e0, input int e1);
        #2;
        chk({name, "_floor"}, int'(uo0), e0);
        chk({name, "_round"}, int'(uo1), e1);
    endtask
    task automatic run(input int r, input int x, input int e0, input int e1);
        set_in(r, x);
        tick(19);
        lit($sformatf("r%0d_x%0d", r, x), e0, e1);
    endtask

    initial begin
        int r, x;
        tick(2);
        lit("reset", 0, 0);
        rst_n = 1'b1;
        tick(1);
        set_in(5, 3);
        tick(17);
        lit("r5x3_before_edge17", 0, 0);
        tick(1);
        lit("r5x3_edge17", 4, 4);
        tick(1);
        run(25, 7, 24, 24);
        run(255, 0, 255, 255);
        run(20, 10, 17, 17);
        run(18, 10, 14, 15);
        run(3, 5, 0, 0);
        run(9, 9, 0, 0);
        set_in(25, 7);
        tick(5);
        set_in(5, 4);
        tick(12);
        lit("change_before17", 0, 0);
        tick(1);
        lit("change_first", 24, 24);
        tick(17);
        lit("change_hold", 24, 24);
        tick(1);
        lit("change_second", 3, 3);
        tick(1);
        set_in(13, 5);
        tick(12);
        ena = 1'b0;
        tick(10);
        ena = 1'b1;
        tick(5);
        lit("ena_delayed", 3, 3);
        tick(1);
        lit("ena_result", 12, 12);
        tick(1);
        set_in(200, 100);
        tick(3);
        rst_n = 1'b0;
        set_in(13, 5);
        lit("async_reset", 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(17);
        lit("after_reset_pending", 0, 0);
        tick(1);
        lit("after_reset_result", 12, 12);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            lit("hold_stable", 12, 12);
        end
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 255));
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, r));
            set_in(r, x);
            ena = ($urandom_range(0, 7) != 0);
            tick(int'($urandom_range(1, 25)));
        end
        ena = 1'b1;
        tick(40);
        lit("random_final", int'(leg_floor(int'(ui_in), int'(uio_in))), int'(leg_round(int'(ui_in), int'(uio_in))));
        tick(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
